axi_lite_arbiter: RTL and testbench

- Shares the core's single AXI4-Lite master port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Each requester drives a simple request/ack interface. The block arbitrates between them and sequences the full AXI read (AR→R) or write (AW+W→B) transaction.
- It returns read data and an error flag on a one-cycle ack.
- It sits between the core FSM and the MMU/bus interconnect. It replaces the core's inline AXI sequencing.

---
 rtl/axi_lite_arbiter_if.sv | 39 +++
 rtl/axi_lite_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite master bus shared by the two requesters of axi_lite_arbiter.
// The master modport is the arbiter side, the slave modport the interconnect side.
interface axi_lite_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [2:0]        arprot;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic [2:0]        awprot;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, arprot, rready,
        output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arprot, rready,
        input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-port request/ack front end that arbitrates for one AXI4-Lite master port and
// sequences a complete read (AR->R) or write (AW+W->B) transaction per grant.
module axi_lite_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    axi_lite_arbiter_if.master axi
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & WORD_MASK;
    endfunction

    logic [2:0]        state;
    logic              last_grant;
    logic              gnt;
    logic              aw_done;
    logic              w_done;

    logic              gnt_vld;
    logic              gnt_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              aw_fire;
    logic              w_fire;

    // On contention the round-robin choice is simply the port that did not win last time.
    always_comb begin
        gnt_vld = m0_req | m1_req;
        gnt_sel = m1_req;
        if (m0_req && m1_req) begin
            gnt_sel = (ROUND_ROBIN != 0) ? ~last_grant : 1'b1;
        end
        sel_we    = gnt_sel ? m1_we    : m0_we;
        sel_addr  = gnt_sel ? m1_addr  : m0_addr;
        sel_wdata = gnt_sel ? m1_wdata : m0_wdata;
        sel_wstrb = gnt_sel ? m1_wstrb : m0_wstrb;
    end

    assign aw_fire = axi.awvalid & axi.awready;
    assign w_fire  = axi.wvalid  & axi.wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gnt         <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            axi.araddr  <= '0;
            axi.arvalid <= 1'b0;
            axi.arprot  <= 3'b000;
            axi.rready  <= 1'b0;
            axi.awaddr  <= '0;
            axi.awvalid <= 1'b0;
            axi.awprot  <= 3'b000;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            m0_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_ack      <= 1'b0;
            m1_err      <= 1'b0;
            m1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        gnt        <= gnt_sel;
                        last_grant <= gnt_sel;
                        if (sel_we) begin
                            axi.awaddr  <= align_word(sel_addr);
                            axi.wdata   <= sel_wdata;
                            axi.wstrb   <= sel_wstrb;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= WRITE;
                        end else begin
                            axi.araddr  <= align_word(sel_addr);
                            axi.arvalid <= 1'b1;
                            state       <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        if (gnt) begin
                            m1_rdata <= axi.rdata;
                            m1_err   <= (axi.rresp != 2'b00);
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= axi.rdata;
                            m0_err   <= (axi.rresp != 2'b00);
                            m0_ack   <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                // AW and W complete independently; either may finish first or both together.
                WRITE: begin
                    if (aw_fire) begin
                        axi.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_fire) begin
                        axi.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        axi.bready <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        if (gnt) begin
                            m1_err <= (axi.bresp != 2'b00);
                            m1_ack <= 1'b1;
                        end else begin
                            m0_err <= (axi.bresp != 2'b00);
                            m0_ack <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                // Requests are not sampled here, so a requester still holding req in its
                // ack cycle is not granted a second time.
                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: two DUTs (round-robin and fixed priority),
// each with a configurable-wait AXI4-Lite slave and an ack monitor.
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic        p_req   [2];
    logic        p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_wstrb [2];

    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic        rd_by_addr = 1'b0;
    logic [31:0] rd_fixed   = 32'h0;
    logic [1:0]  rresp_v    = 2'b00;
    logic [1:0]  bresp_v    = 2'b00;

    typedef struct {
        int          inst;
        int          port;
        logic        is_wr;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl_rd [2][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ack(input int g, input int port, input logic [31:0] rdata, input logic err,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: inst %0d port %0d acked with nothing outstanding (cycle %0d)", g, port, cyc);
            return;
        end
        e = sbq.pop_front();
        chk("ack_inst", g, e.inst);
        chk("ack_port", port, e.port);
        chk("ack_rdata", rdata, e.rdata);
        chk("ack_err", {31'b0, err}, {31'b0, e.err});
        chk("bus_addr", addr, e.addr);
        chk("ack_cycle", cyc, e.cyc);
        if (e.is_wr) begin
            chk("bus_wdata", wdata, e.wdata);
            chk("bus_wstrb", {28'b0, wstrb}, {28'b0, e.wstrb});
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_lite_arbiter_if #(.ADDR_W(32)) axi ();
        logic        m0_ack, m0_err, m1_ack, m1_err;
        logic [31:0] m0_rdata, m1_rdata;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

        axi_lite_arbiter #(.ADDR_W(32), .ROUND_ROBIN(g == 0 ? 1 : 0)) dut (
            .clk      (clk),
            .rst      (rst),
            .m0_req   (p_req[0] && (sel == g)),
            .m0_we    (p_we[0]),
            .m0_addr  (p_addr[0]),
            .m0_wdata (p_wdata[0]),
            .m0_wstrb (p_wstrb[0]),
            .m0_ack   (m0_ack),
            .m0_rdata (m0_rdata),
            .m0_err   (m0_err),
            .m1_req   (p_req[1] && (sel == g)),
            .m1_we    (p_we[1]),
            .m1_addr  (p_addr[1]),
            .m1_wdata (p_wdata[1]),
            .m1_wstrb (p_wstrb[1]),
            .m1_ack   (m1_ack),
            .m1_rdata (m1_rdata),
            .m1_err   (m1_err),
            .axi      (axi)
        );

        // Slave: each ready/valid rises after the configured number of wait cycles.
        initial begin
            axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            s_addr = 32'h0; s_wdata = 32'h0; s_wstrb = 4'h0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            forever begin
                @(negedge clk);
                if (!axi.arvalid) begin axi.arready = 1'b0; ar_cnt = 0; end
                else if (ar_cnt >= ar_wait) begin axi.arready = 1'b1; s_addr = axi.araddr; end
                else begin axi.arready = 1'b0; ar_cnt++; end
                if (!axi.rready) begin axi.rvalid = 1'b0; r_cnt = 0; end
                else if (r_cnt >= r_wait) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = rd_by_addr ? (s_addr ^ 32'h5A5A0000) : rd_fixed;
                    axi.rresp  = rresp_v;
                end
                else begin axi.rvalid = 1'b0; r_cnt++; end
                if (!axi.awvalid) begin axi.awready = 1'b0; aw_cnt = 0; end
                else if (aw_cnt >= aw_wait) begin axi.awready = 1'b1; s_addr = axi.awaddr; end
                else begin axi.awready = 1'b0; aw_cnt++; end
                if (!axi.wvalid) begin axi.wready = 1'b0; w_cnt = 0; end
                else if (w_cnt >= w_wait) begin axi.wready = 1'b1; s_wdata = axi.wdata; s_wstrb = axi.wstrb; end
                else begin axi.wready = 1'b0; w_cnt++; end
                if (!axi.bready) begin axi.bvalid = 1'b0; b_cnt = 0; end
                else if (b_cnt >= b_wait) begin axi.bvalid = 1'b1; axi.bresp = bresp_v; end
                else begin axi.bvalid = 1'b0; b_cnt++; end
            end
        end

        always @(negedge clk) begin
            if (m0_ack) check_ack(g, 0, m0_rdata, m0_err, s_addr, s_wdata, s_wstrb);
            if (m1_ack) check_ack(g, 1, m1_rdata, m1_err, s_addr, s_wdata, s_wstrb);
        end
    end

    function automatic logic cur_ack(input int port);
        if (sel == 0) return (port == 0) ? g_dut[0].m0_ack : g_dut[0].m1_ack;
        return (port == 0) ? g_dut[1].m0_ack : g_dut[1].m1_ack;
    endfunction

    task automatic push_exp(input int g, input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] bus_rdata,
                            input logic err, input int ack_cyc);
        exp_t e;
        e.inst = g; e.port = port; e.is_wr = we; e.addr = addr;
        e.wdata = wdata; e.wstrb = wstrb; e.err = err; e.cyc = ack_cyc;
        if (we) e.rdata = mdl_rd[g][port];
        else begin
            e.rdata = bus_rdata;
            mdl_rd[g][port] = bus_rdata;
        end
        sbq.push_back(e);
    endtask

    task automatic start(input int g, input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] exp_addr,
                         input logic [31:0] bus_rdata, input logic err, input int lat);
        @(negedge clk);
        sel = g;
        p_we[port] = we; p_addr[port] = addr; p_wdata[port] = wdata; p_wstrb[port] = wstrb;
        p_req[port] = 1'b1;
        push_exp(g, port, we, exp_addr, wdata, wstrb, bus_rdata, err, cyc + lat);
    endtask

    task automatic wait_ack(input int port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = cur_ack(port);
        end
        p_req[port] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: port %0d got no ack within 200 cycles, required an ack", port);
        end
    endtask

    task automatic contend(input int g, input int p0, input int p1, input int p2, input int p3);
        int ports[4];
        int c0, n;
        ports[0] = p0; ports[1] = p1; ports[2] = p2; ports[3] = p3;
        @(negedge clk);
        sel = g;
        p_we[0] = 1'b0; p_addr[0] = 32'h0000_0100;
        p_we[1] = 1'b0; p_addr[1] = 32'h0000_0204;
        p_req[0] = 1'b1; p_req[1] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            if (ports[k] == 0) push_exp(g, 0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h5A5A_0100, 1'b0, c0 + 3 + 4 * k);
            else               push_exp(g, 1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 32'h5A5A_0204, 1'b0, c0 + 3 + 4 * k);
        end
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (cur_ack(0) || cur_ack(1)) n++;
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        chk("contention_ack_count", n, 4);
    endtask

    logic [2:0] skew_exp [5];

    initial begin
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'h0; p_wdata[p] = 32'h0; p_wstrb[p] = 4'h0;
            mdl_rd[0][p] = 32'h0; mdl_rd[1][p] = 32'h0;
        end
        skew_exp[0] = 3'b110; skew_exp[1] = 3'b110; skew_exp[2] = 3'b100;
        skew_exp[3] = 3'b100; skew_exp[4] = 3'b001;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", {31'b0, g_dut[0].axi.arvalid}, 32'h0);
        chk("rst_awvalid_wvalid", {30'b0, g_dut[0].axi.awvalid, g_dut[0].axi.wvalid}, 32'h0);
        chk("rst_rready_bready", {30'b0, g_dut[0].axi.rready, g_dut[0].axi.bready}, 32'h0);
        chk("rst_acks", {30'b0, g_dut[0].m1_ack, g_dut[0].m0_ack}, 32'h0);
        chk("rst_araddr", g_dut[0].axi.araddr, 32'h0);
        chk("rst_prot", {26'b0, g_dut[0].axi.arprot, g_dut[0].axi.awprot}, 32'h0);
        rst = 1'b0;

        // Single zero-wait read of an unaligned address.
        rd_fixed = 32'hDEAD_BEEF;
        start(0, 0, 1'b0, 32'h0000_1006, 32'h0, 4'h0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 3);
        @(negedge clk);
        chk("read_arvalid_c1", {31'b0, g_dut[0].axi.arvalid}, 32'h1);
        chk("read_araddr_c1", g_dut[0].axi.araddr, 32'h0000_1004);
        wait_ack(0);

        // SLVERR read, then an OKAY read must clear err.
        rresp_v = 2'b10; rd_fixed = 32'h1234_5678;
        start(0, 0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0040, 32'h1234_5678, 1'b1, 3);
        wait_ack(0);
        rresp_v = 2'b00; rd_fixed = 32'h0BAD_F00D;
        start(0, 0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0000_0044, 32'h0BAD_F00D, 1'b0, 3);
        wait_ack(0);

        // Write with W accepted after 1 wait and AW after 3; {awvalid,wvalid,bready} per cycle.
        w_wait = 1; aw_wait = 3;
        start(0, 1, 1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h0000_0020, 32'h0, 1'b0, 6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("skew_valids_c%0d", k + 1),
                {29'b0, g_dut[0].axi.awvalid, g_dut[0].axi.wvalid, g_dut[0].axi.bready}, {29'b0, skew_exp[k]});
        end
        wait_ack(1);
        w_wait = 0; aw_wait = 0;

        // Write with DECERR response.
        bresp_v = 2'b11;
        start(0, 1, 1'b1, 32'h0000_002A, 32'h1122_3344, 4'b1111, 32'h0000_0028, 32'h0, 1'b1, 3);
        wait_ack(1);
        bresp_v = 2'b00;

        // Round-robin contention: last winner was port 1.
        rd_by_addr = 1'b1;
        contend(0, 0, 1, 0, 1);
        rd_by_addr = 1'b0;

        // AR backpressure for 10 cycles.
        ar_wait = 10; rd_fixed = 32'hCAFE_F00D;
        start(0, 0, 1'b0, 32'h0000_2008, 32'h0, 4'h0, 32'h0000_2008, 32'hCAFE_F00D, 1'b0, 13);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_arvalid", {31'b0, g_dut[0].axi.arvalid}, 32'h1);
            chk("bp_araddr", g_dut[0].axi.araddr, 32'h0000_2008);
        end
        wait_ack(0);
        ar_wait = 0;

        // Reset while waiting in RDATA abandons the read without an ack.
        r_wait = 50;
        @(negedge clk);
        sel = 0; p_we[0] = 1'b0; p_addr[0] = 32'h0000_0300; p_req[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrd_rready", {31'b0, g_dut[0].axi.rready}, 32'h1);
        rst = 1'b1; p_req[0] = 1'b0;
        @(negedge clk);
        chk("midrd_valids_after_rst", {30'b0, g_dut[0].axi.arvalid, g_dut[0].axi.rready}, 32'h0);
        chk("midrd_no_ack", {31'b0, g_dut[0].m0_ack}, 32'h0);
        rst = 1'b0; r_wait = 0;
        for (int p = 0; p < 2; p++) begin mdl_rd[0][p] = 32'h0; mdl_rd[1][p] = 32'h0; end
        repeat (5) @(negedge clk);
        rd_fixed = 32'h600D_CAFE;
        start(0, 0, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 32'h0000_0304, 32'h600D_CAFE, 1'b0, 3);
        wait_ack(0);

        // Fixed priority instance: port 1 wins every contention.
        rd_by_addr = 1'b1;
        contend(1, 1, 1, 1, 1);
        rd_by_addr = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
